// File: rtl/half_subtractor_if.sv
// Lane operand/result bundle for the half subtractor.
// The block drives results through the slave modport; a producer uses master.
interface half_subtractor_if #(
   parameter int WIDTH = 1,
   parameter int CNT_W = 16
);
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             in_valid;
   logic             cnt_clr;
   logic [WIDTH-1:0] Difference;
   logic [WIDTH-1:0] Borrow;
   logic [WIDTH-1:0] diff_q;
   logic [WIDTH-1:0] borrow_q;
   logic             out_valid;
   logic [CNT_W-1:0] borrow_cnt;

   modport master (
      output A, B, in_valid, cnt_clr,
      input  Difference, Borrow, diff_q, borrow_q, out_valid, borrow_cnt
   );

   modport slave (
      input  A, B, in_valid, cnt_clr,
      output Difference, Borrow, diff_q, borrow_q, out_valid, borrow_cnt
   );
endinterface

// File: rtl/half_subtractor.sv
// Vector of independent 1-bit half subtractors (A - B per lane).
// Combinational difference/borrow, a valid-qualified registered copy,
// and a saturating count of captures that carried any borrow.

// One lane: comb result plus its capture register.
module half_subtractor_lane (
   input  logic clk,
   input  logic rst_n,
   input  logic a_i,
   input  logic b_i,
   input  logic cap_i,
   output logic diff_o,
   output logic borrow_o,
   output logic diff_q_o,
   output logic borrow_q_o
);
   logic diff_q;
   logic borrow_q;

   assign diff_o   = a_i ^ b_i;
   assign borrow_o = ~a_i & b_i;

   // Capture the comb result on a valid edge, otherwise hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         diff_q   <= 1'b0;
         borrow_q <= 1'b0;
      end else if (cap_i) begin
         diff_q   <= diff_o;
         borrow_q <= borrow_o;
      end
   end

   assign diff_q_o   = diff_q;
   assign borrow_q_o = borrow_q;
endmodule

module half_subtractor #(
   parameter int WIDTH = 1,
   parameter int CNT_W = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   half_subtractor_if.slave    bus
);
   logic [WIDTH-1:0] diff;
   logic [WIDTH-1:0] borrow;
   logic [WIDTH-1:0] diff_q;
   logic [WIDTH-1:0] borrow_q;
   logic             out_valid_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // No borrow chaining: every lane sees only its own A/B bit.
   for (genvar g = 0; g < WIDTH; g++) begin : g_lane
      half_subtractor_lane u_lane (
         .clk        (clk),
         .rst_n      (rst_n),
         .a_i        (bus.A[g]),
         .b_i        (bus.B[g]),
         .cap_i      (bus.in_valid),
         .diff_o     (diff[g]),
         .borrow_o   (borrow[g]),
         .diff_q_o   (diff_q[g]),
         .borrow_q_o (borrow_q[g])
      );
   end

   // Valid follows in_valid by one cycle; a reset drops any in-flight capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) out_valid_q <= 1'b0;
      else        out_valid_q <= bus.in_valid;
   end

   // Counter next state: clear wins, then saturating increment on a borrow capture.
   always_comb begin
      cnt_d = cnt_q;
      if (bus.cnt_clr)
         cnt_d = '0;
      else if (bus.in_valid && (|borrow) && (cnt_q != {CNT_W{1'b1}}))
         cnt_d = cnt_q + CNT_W'(1);
   end

   // Borrow-event counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign bus.Difference = diff;
   assign bus.Borrow     = borrow;
   assign bus.diff_q     = diff_q;
   assign bus.borrow_q   = borrow_q;
   assign bus.out_valid  = out_valid_q;
   assign bus.borrow_cnt = cnt_q;
endmodule

// File: tb/tb_half_subtractor.sv
// Bench: narrow instance (WIDTH=1, CNT_W=2) for comb sweep and saturation,
// wide instance (WIDTH=4, CNT_W=16) for vectors, random sweep and reset.
module tb_half_subtractor;
   logic clk;
   logic rst_n;
   logic clk_en;
   int   n_tests;
   int   n_fail;

   half_subtractor_if #(.WIDTH(1), .CNT_W(2))  if_a ();
   half_subtractor_if #(.WIDTH(4), .CNT_W(16)) if_b ();

   half_subtractor #(.WIDTH(1), .CNT_W(2)) u_a (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if_a)
   );

   half_subtractor #(.WIDTH(4), .CNT_W(16)) u_b (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if_b)
   );

   initial begin
      clk = 1'b0;
      wait (clk_en);
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: per-lane A-B as a signed integer, encoded in 2-bit two's complement.
   function automatic logic [7:0] ref_sub(input logic [3:0] a, input logic [3:0] b);
      logic [3:0] d;
      logic [3:0] br;
      logic [1:0] enc;
      int         v;
      for (int l = 0; l < 4; l++) begin
         v     = int'(a[l]) - int'(b[l]);
         enc   = 2'(v);
         d[l]  = enc[0];
         br[l] = enc[1];
      end
      return {br, d};
   endfunction

   logic [3:0] ra, rb;
   logic [7:0] rr;
   logic [3:0] m_dq, m_bq;
   logic       m_ov;
   logic       rv, rc;
   int         m_cnt;

   initial begin
      n_tests = 0; n_fail = 0; clk_en = 1'b0; rst_n = 1'b0;
      if_a.A = '0; if_a.B = '0; if_a.in_valid = 1'b0; if_a.cnt_clr = 1'b0;
      if_b.A = '0; if_b.B = '0; if_b.in_valid = 1'b0; if_b.cnt_clr = 1'b0;

      // Combinational sweep with no clock and reset held.
      for (int i = 0; i < 4; i++) begin
         if_a.A = 1'(i >> 1);
         if_a.B = 1'(i);
         #20;
         chk("comb_diff", 64'(if_a.Difference), 64'((i == 1 || i == 2) ? 1 : 0));
         chk("comb_borrow", 64'(if_a.Borrow), 64'((i == 1) ? 1 : 0));
      end
      chk("rst_diff_q", 64'(if_b.diff_q), 64'd0);
      chk("rst_borrow_q", 64'(if_b.borrow_q), 64'd0);
      chk("rst_out_valid", 64'(if_b.out_valid), 64'd0);
      chk("rst_cnt", 64'(if_b.borrow_cnt), 64'd0);

      clk_en = 1'b1;
      #12 rst_n = 1'b1;

      // Registered capture of 0-1.
      @(negedge clk);
      if_a.A = 1'b0; if_a.B = 1'b1; if_a.in_valid = 1'b1;
      @(posedge clk); #1;
      chk("cap_diff_q", 64'(if_a.diff_q), 64'd1);
      chk("cap_borrow_q", 64'(if_a.borrow_q), 64'd1);
      chk("cap_out_valid", 64'(if_a.out_valid), 64'd1);
      chk("cap_cnt", 64'(if_a.borrow_cnt), 64'd1);
      @(negedge clk);
      if_a.A = 1'b1; if_a.B = 1'b0; if_a.in_valid = 1'b0;
      @(posedge clk); #1;
      chk("hold_out_valid", 64'(if_a.out_valid), 64'd0);
      chk("hold_diff_q", 64'(if_a.diff_q), 64'd1);
      chk("hold_borrow_q", 64'(if_a.borrow_q), 64'd1);
      chk("hold_cnt", 64'(if_a.borrow_cnt), 64'd1);

      // Saturation at 3 for CNT_W=2.
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if_a.A = 1'b0; if_a.B = 1'b1; if_a.in_valid = 1'b1;
         @(posedge clk); #1;
         chk("sat_cnt", 64'(if_a.borrow_cnt), 64'((i + 2 > 3) ? 3 : i + 2));
      end
      // Clear wins over a simultaneous borrow capture.
      @(negedge clk);
      if_a.cnt_clr = 1'b1;
      @(posedge clk); #1;
      chk("clr_cnt", 64'(if_a.borrow_cnt), 64'd0);
      @(negedge clk);
      if_a.cnt_clr = 1'b0; if_a.in_valid = 1'b0;

      // WIDTH=4 vector.
      if_b.A = 4'b1010; if_b.B = 4'b0110; if_b.in_valid = 1'b1;
      #1;
      chk("vec_diff", 64'(if_b.Difference), 64'hC);
      chk("vec_borrow", 64'(if_b.Borrow), 64'h4);
      @(posedge clk); #1;
      chk("vec_diff_q", 64'(if_b.diff_q), 64'hC);
      chk("vec_borrow_q", 64'(if_b.borrow_q), 64'h4);
      chk("vec_cnt", 64'(if_b.borrow_cnt), 64'd1);

      // Random sweep against the reference model.
      m_dq = 4'hC; m_bq = 4'h4; m_ov = 1'b1; m_cnt = 1;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         ra = 4'($urandom); rb = 4'($urandom);
         rv = ($urandom_range(0, 3) != 0);
         rc = ($urandom_range(0, 49) == 0);
         if_b.A = ra; if_b.B = rb; if_b.in_valid = rv; if_b.cnt_clr = rc;
         rr = ref_sub(ra, rb);
         #1;
         chk("rnd_diff", 64'(if_b.Difference), 64'(rr[3:0]));
         chk("rnd_borrow", 64'(if_b.Borrow), 64'(rr[7:4]));
         if (rv) begin m_dq = rr[3:0]; m_bq = rr[7:4]; end
         m_ov = rv;
         if (rc) m_cnt = 0;
         else if (rv && rr[7:4] != 4'd0 && m_cnt < 65535) m_cnt++;
         @(posedge clk); #1;
         chk("rnd_out_valid", 64'(if_b.out_valid), 64'(m_ov));
         chk("rnd_diff_q", 64'(if_b.diff_q), 64'(m_dq));
         chk("rnd_borrow_q", 64'(if_b.borrow_q), 64'(m_bq));
         chk("rnd_cnt", 64'(if_b.borrow_cnt), 64'(m_cnt));
      end

      // Async reset between edges while out_valid is high.
      @(negedge clk);
      if_b.A = 4'b0000; if_b.B = 4'b1111; if_b.in_valid = 1'b1; if_b.cnt_clr = 1'b0;
      @(posedge clk); #1;
      chk("pre_rst_valid", 64'(if_b.out_valid), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_diff_q", 64'(if_b.diff_q), 64'd0);
      chk("arst_borrow_q", 64'(if_b.borrow_q), 64'd0);
      chk("arst_out_valid", 64'(if_b.out_valid), 64'd0);
      chk("arst_cnt", 64'(if_b.borrow_cnt), 64'd0);
      if_b.A = 4'b1100; if_b.B = 4'b0101;
      #1;
      chk("arst_comb_diff", 64'(if_b.Difference), 64'h9);
      chk("arst_comb_borrow", 64'(if_b.Borrow), 64'h1);
      @(posedge clk); #1;
      chk("arst_held_valid", 64'(if_b.out_valid), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rel_out_valid", 64'(if_b.out_valid), 64'd1);
      chk("rel_diff_q", 64'(if_b.diff_q), 64'h9);
      chk("rel_borrow_q", 64'(if_b.borrow_q), 64'h1);
      chk("rel_cnt", 64'(if_b.borrow_cnt), 64'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
